count_seq_monitor: RTL and testbench

//  Downstream checker for the registered 3-bit counter value bus (counter -> DFF stage -> Values).

---
 rtl/count_seq_monitor.sv | 105 ++++++++++
 tb/tb_count_seq_monitor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks a registered counter value bus for strict +1 (mod 2^WIDTH) steps.
// Acquires lock after LOCK_COUNT consecutive good steps. While locked it flags sequence errors,
// keeps a saturating error count and pulses on max -> 0 wrap-around. All outputs are registered.
// Optional feature: define SEQMON_HOLD_OK_EN to treat a repeated sample (stalled counter) as a
// HOLD instead of a mismatch.
module count_seq_monitor #(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     value_in,
    input  logic                 clear_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected,
    output logic                 wrap_pulse
);

    typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

    state_e           state;
    logic [3:0]       match_cnt;
    logic [WIDTH-1:0] next_value;
    logic             match;
    logic             hold;
    logic             is_error;
    logic             err_sat;

    assign next_value = value_in + WIDTH'(1);
    assign match      = (value_in == expected);

`ifdef SEQMON_HOLD_OK_EN
    // A repeat of the last accepted value means the counter stalled; it is neither good nor bad.
    assign hold = (state != StIdle) && (value_in == expected - WIDTH'(1));
`else
    assign hold = 1'b0;
`endif

    assign is_error = valid_in && !hold && (state == StLocked) && !match;
    assign err_sat  = &err_count;

    // Sequence FSM with registered lock, pulse and expected-value outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            match_cnt  <= 4'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            expected   <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (valid_in && !hold) begin
                expected <= next_value;
                unique case (state)
                    StIdle: begin
                        state     <= StAcquire;
                        match_cnt <= 4'd0;
                    end
                    StAcquire: begin
                        if (match) begin
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LockCnt) begin
                                state  <= StLocked;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= 4'd0;
                        end
                    end
                    StLocked: begin
                        if (match) begin
                            wrap_pulse <= (value_in == '0);
                        end else begin
                            state     <= StAcquire;
                            locked    <= 1'b0;
                            err_pulse <= 1'b1;
                            match_cnt <= 4'd0;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    // Saturating error counter; a clear coinciding with an error keeps that new error.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (clear_err) begin
            err_count <= is_error ? ERR_CNT_W'(1) : '0;
        end else if (is_error && !err_sat) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Self-checking bench for count_seq_monitor: directed scenarios plus randomized traffic checked
// against a behavioural model. Two instances share stimulus: default ERR_CNT_W and ERR_CNT_W=2.
module tb_count_seq_monitor;

    localparam int W    = 3;
    localparam int MODV = 8;
    localparam int LOCK = 4;
`ifdef SEQMON_HOLD_OK_EN
    localparam bit HoldEn = 1'b1;
`else
    localparam bit HoldEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         valid_in = 1'b0;
    logic [W-1:0] value_in = '0;
    logic         clear_err = 1'b0;

    logic         a_locked, a_err_pulse, a_wrap_pulse;
    logic [7:0]   a_err_count;
    logic [W-1:0] a_expected;
    logic         b_locked, b_err_pulse, b_wrap_pulse;
    logic [1:0]   b_err_count;
    logic [W-1:0] b_expected;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit m_seen, m_lk, m_ep, m_wp;
    int m_exp, m_run, m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    count_seq_monitor #(.WIDTH(W), .LOCK_COUNT(LOCK), .ERR_CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .valid_in(valid_in), .value_in(value_in),
        .clear_err(clear_err), .locked(a_locked), .err_pulse(a_err_pulse),
        .err_count(a_err_count), .expected(a_expected), .wrap_pulse(a_wrap_pulse)
    );

    count_seq_monitor #(.WIDTH(W), .LOCK_COUNT(LOCK), .ERR_CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .valid_in(valid_in), .value_in(value_in),
        .clear_err(clear_err), .locked(b_locked), .err_pulse(b_err_pulse),
        .err_count(b_err_count), .expected(b_expected), .wrap_pulse(b_wrap_pulse)
    );

    // Drive one cycle of inputs, advance the model across the edge, sample #1 after it.
    task automatic step(input bit r, input bit v, input int val, input bit clr);
        bit err;
        @(negedge clk);
        reset = r; valid_in = v; value_in = W'(val); clear_err = clr;
        @(posedge clk);
        err = 1'b0;
        if (r) begin
            m_seen = 0; m_lk = 0; m_ep = 0; m_wp = 0; m_exp = 0; m_run = 0;
            m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            m_ep = 0; m_wp = 0;
            if (v) begin
                if (!m_seen) begin
                    m_seen = 1; m_run = 0; m_exp = (val + 1) % MODV;
                end else if (HoldEn && val == (m_exp + MODV - 1) % MODV) begin
                    // stalled counter: nothing changes
                end else if (val == m_exp) begin
                    if (m_lk) begin
                        m_wp = (val == 0);
                    end else begin
                        m_run++;
                        if (m_run == LOCK) m_lk = 1;
                    end
                    m_exp = (val + 1) % MODV;
                end else begin
                    if (m_lk) begin
                        m_ep = 1; err = 1; m_lk = 0;
                    end
                    m_run = 0;
                    m_exp = (val + 1) % MODV;
                end
            end
            if (clr) begin
                m_cnt8 = err ? 1 : 0;
                m_cnt2 = err ? 1 : 0;
            end else if (err) begin
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        checks++;
        if ({a_locked, a_err_pulse, a_wrap_pulse, a_err_count, a_expected} !== '0) begin
            failures++;
            $display("FAIL reset_a: got lk=%0b ep=%0b wp=%0b cnt=%0d exp=%0d, want all 0",
                     a_locked, a_err_pulse, a_wrap_pulse, a_err_count, a_expected);
        end
        checks++;
        if ({b_locked, b_err_pulse, b_wrap_pulse, b_err_count, b_expected} !== '0) begin
            failures++;
            $display("FAIL reset_b: got lk=%0b cnt=%0d exp=%0d, want all 0",
                     b_locked, b_err_count, b_expected);
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i <= 4; i++) begin
            step(0, 1, i, 0);
            checks++;
            if (a_locked !== (i == 4)) begin
                failures++;
                $display("FAIL lock_s%0d: locked=%0b want %0b", i, a_locked, (i == 4));
            end
        end
        checks++;
        if (a_expected !== 3'd5) begin
            failures++;
            $display("FAIL lock_expected: got %0d want 5", a_expected);
        end
    endtask

    task automatic test_wrap();
        int vals[5] = '{5, 6, 7, 0, 1};
        for (int i = 0; i < 5; i++) begin
            step(0, 1, vals[i], 0);
            checks++;
            if (a_wrap_pulse !== (vals[i] == 0) || a_err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL wrap_s%0d: wp=%0b ep=%0b want wp=%0b ep=0",
                         vals[i], a_wrap_pulse, a_err_pulse, (vals[i] == 0));
            end
        end
        checks++;
        if (a_expected !== 3'd2) begin
            failures++;
            $display("FAIL wrap_expected: got %0d want 2", a_expected);
        end
    endtask

    task automatic test_error();
        int rec[4] = '{6, 7, 0, 1};
        step(0, 1, 2, 0);
        step(0, 1, 3, 0);
        step(0, 1, 5, 0);
        checks++;
        if (a_err_pulse !== 1'b1 || a_err_count !== 8'd1 || a_locked !== 1'b0
            || a_expected !== 3'd6) begin
            failures++;
            $display("FAIL error_hit: ep=%0b cnt=%0d lk=%0b exp=%0d want 1,1,0,6",
                     a_err_pulse, a_err_count, a_locked, a_expected);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, rec[i], 0);
            checks++;
            if (a_locked !== (i == 3) || a_err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL relock_s%0d: lk=%0b ep=%0b want lk=%0b ep=0",
                         rec[i], a_locked, a_err_pulse, (i == 3));
            end
        end
    endtask

    task automatic test_saturation();
        step(1, 0, 0, 0);
        for (int i = 0; i <= 4; i++) step(0, 1, i, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, (m_exp + 3) % MODV, 0);
            for (int j = 0; j < LOCK; j++) step(0, 1, m_exp, 0);
        end
        checks++;
        if (b_err_count !== 2'd3 || a_err_count !== 8'd5) begin
            failures++;
            $display("FAIL sat_count: small=%0d big=%0d want 3 and 5", b_err_count, a_err_count);
        end
        step(0, 1, (m_exp + 3) % MODV, 1);
        checks++;
        if (b_err_count !== 2'd1 || a_err_count !== 8'd1 || b_err_pulse !== 1'b1) begin
            failures++;
            $display("FAIL clear_with_err: small=%0d big=%0d ep=%0b want 1,1,1",
                     b_err_count, a_err_count, b_err_pulse);
        end
        step(0, 0, 0, 1);
        checks++;
        if (b_err_count !== 2'd0 || a_err_count !== 8'd0) begin
            failures++;
            $display("FAIL clear_alone: small=%0d big=%0d want 0", b_err_count, a_err_count);
        end
    endtask

    task automatic test_gaps_reset();
        for (int j = 0; j < LOCK; j++) step(0, 1, m_exp, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, $urandom_range(0, 7), 0);
            checks++;
            if (a_locked !== 1'b1 || a_expected !== W'(m_exp) || a_err_pulse !== 1'b0
                || a_wrap_pulse !== 1'b0 || a_err_count !== 8'(m_cnt8)) begin
                failures++;
                $display("FAIL gap_hold%0d: lk=%0b exp=%0d ep=%0b wp=%0b cnt=%0d", i,
                         a_locked, a_expected, a_err_pulse, a_wrap_pulse, a_err_count);
            end
        end
        step(0, 1, (m_exp + 3) % MODV, 0);
        step(0, 1, m_exp, 0);
        step(1, 1, (m_exp + 2) % MODV, 0);
        checks++;
        if ({a_locked, a_err_pulse, a_wrap_pulse, a_err_count, a_expected} !== '0) begin
            failures++;
            $display("FAIL reset_acquire: lk=%0b ep=%0b cnt=%0d exp=%0d want all 0",
                     a_locked, a_err_pulse, a_err_count, a_expected);
        end
        step(0, 1, 5, 0);
        checks++;
        if (a_locked !== 1'b0 || a_err_pulse !== 1'b0 || a_expected !== 3'd6) begin
            failures++;
            $display("FAIL after_reset_idle: lk=%0b ep=%0b exp=%0d want 0,0,6",
                     a_locked, a_err_pulse, a_expected);
        end
    endtask

    task automatic test_hold();
        int base;
        for (int j = 0; j < LOCK; j++) step(0, 1, m_exp, 0);
        while (m_exp != 2) step(0, 1, m_exp, 0);
        base = m_cnt8;
        step(0, 1, 2, 0);
        step(0, 1, 2, 0);
        checks++;
        if (HoldEn) begin
            if (a_err_pulse !== 1'b0 || a_locked !== 1'b1 || a_err_count !== 8'(base)) begin
                failures++;
                $display("FAIL hold_repeat: ep=%0b lk=%0b cnt=%0d want 0,1,%0d",
                         a_err_pulse, a_locked, a_err_count, base);
            end
        end else begin
            if (a_err_pulse !== 1'b1 || a_locked !== 1'b0 || a_err_count !== 8'(base + 1)) begin
                failures++;
                $display("FAIL repeat_err: ep=%0b lk=%0b cnt=%0d want 1,0,%0d",
                         a_err_pulse, a_locked, a_err_count, base + 1);
            end
        end
        step(0, 1, 3, 0);
        checks++;
        if (a_expected !== 3'd4 || a_err_pulse !== 1'b0 || a_locked !== HoldEn) begin
            failures++;
            $display("FAIL hold_next: exp=%0d ep=%0b lk=%0b want 4,0,%0b",
                     a_expected, a_err_pulse, a_locked, HoldEn);
        end
    endtask

    task automatic test_random();
        int val;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       val = $urandom_range(0, 7);
                1:       val = (m_exp + MODV - 1) % MODV;
                default: val = m_exp;
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), val,
                 ($urandom_range(0, 24) == 0));
            checks++;
            if (a_locked !== m_lk || a_err_pulse !== m_ep || a_wrap_pulse !== m_wp
                || a_expected !== W'(m_exp) || a_err_count !== 8'(m_cnt8)) begin
                failures++;
                $display("FAIL rand_a%0d: lk=%0b ep=%0b wp=%0b exp=%0d cnt=%0d want %0b %0b %0b %0d %0d",
                         i, a_locked, a_err_pulse, a_wrap_pulse, a_expected, a_err_count,
                         m_lk, m_ep, m_wp, m_exp, m_cnt8);
            end
            checks++;
            if (b_locked !== m_lk || b_err_pulse !== m_ep || b_wrap_pulse !== m_wp
                || b_expected !== W'(m_exp) || b_err_count !== 2'(m_cnt2)) begin
                failures++;
                $display("FAIL rand_b%0d: lk=%0b ep=%0b wp=%0b exp=%0d cnt=%0d want %0b %0b %0b %0d %0d",
                         i, b_locked, b_err_pulse, b_wrap_pulse, b_expected, b_err_count,
                         m_lk, m_ep, m_wp, m_exp, m_cnt2);
            end
            checks++;
            if (a_err_pulse === 1'b1 && a_wrap_pulse === 1'b1) begin
                failures++;
                $display("FAIL pulses_exclusive%0d: ep=1 wp=1 want not both", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_error();
        test_saturation();
        test_gaps_reset();
        test_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
